// File: rtl/instr_fetch_queue_if.sv
// Decode-side handshake bundle for the instruction fetch queue.
//   id_valid : head entry valid            (queue -> decode)
//   id_instr : head instruction, 0 if empty (queue -> decode)
//   id_pc    : PC of head instruction       (queue -> decode)
//   id_ready : decode accepts head entry    (decode -> queue)
// master = the queue, slave = the decode stage.
interface instr_fetch_queue_if;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [4:0]  id_pc;

  modport master (output id_valid, output id_instr, output id_pc, input id_ready);
  modport slave  (input id_valid, input id_instr, input id_pc, output id_ready);
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage with a small tagged FIFO.
// Each cycle with fetch_en set, four consecutive bytes (little-endian,
// addresses mod 32) of a 32x8 instruction memory are read at pc_in and pushed,
// tagged with pc_in, into a DEPTH-entry FIFO drained by decode via id_bus.
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   pc_in, fetch_en   fetch address and push request
//   flush             discard all queued entries at the next edge
//   mem_we/waddr/wdata byte write port of the instruction memory
//   id_bus            decode handshake (valid/ready, instr, pc)
//   q_count, q_full   occupancy and full flag
//   drop_count        saturating count of fetches lost to a full queue
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4:0]               pc_in,
  input  logic                     fetch_en,
  input  logic                     flush,
  input  logic                     mem_we,
  input  logic [4:0]               mem_waddr,
  input  logic [7:0]               mem_wdata,
  instr_fetch_queue_if.master      id_bus,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     q_full,
  output logic [CNT_W-1:0]         drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [7:0]       imem [32];
  logic [31:0]      q_instr [DEPTH];
  logic [4:0]       q_pc [DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0] drops;

  logic [4:0]       a1, a2, a3;
  logic [31:0]      fetch_word;
  logic             full, valid, push, pop, do_write, drop;

  // Memory: no reset, write commits at the edge, so a same-cycle fetch sees
  // the old byte through the combinational read below.
  always_ff @(posedge clk) begin
    if (mem_we) imem[mem_waddr] <= mem_wdata;
  end

  assign a1 = pc_in + 5'd1;
  assign a2 = pc_in + 5'd2;
  assign a3 = pc_in + 5'd3;
  assign fetch_word = {imem[a3], imem[a2], imem[a1], imem[pc_in]};

  assign full  = (cnt == FULL_CNT);
  assign valid = (cnt != '0);
  assign push  = fetch_en & ~flush;
  assign pop   = valid & id_bus.id_ready;
  // When full, a concurrent pop frees the slot the push lands in.
  assign do_write = push & (~full | pop);
  assign drop     = push & full & ~pop;

  always_comb begin
    cnt_nxt = cnt;
    case ({do_write, pop})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  // Entry storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_write) begin
      q_instr[wr_ptr] <= fetch_word;
      q_pc[wr_ptr]    <= pc_in;
    end
  end

  // Queue control: flush overrides any push/pop but leaves drops alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      drops  <= '0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (do_write) wr_ptr <= wr_ptr + 1'b1;
        if (pop)      rd_ptr <= rd_ptr + 1'b1;
        cnt <= cnt_nxt;
        if (drop) drops <= sat_inc(drops);
      end
    end
  end

  assign id_bus.id_valid = valid;
  assign id_bus.id_instr = valid ? q_instr[rd_ptr] : 32'd0;
  assign id_bus.id_pc    = valid ? q_pc[rd_ptr] : 5'd0;
  assign q_count         = cnt;
  assign q_full          = full;
  assign drop_count      = drops;

endmodule
